// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle restoring divider: FSM encoding and
// sizing helpers used by the top level.
package div_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_ZERO = 2'd3
  } state_e;

  // Iteration counter width: clog2(N)+1 bits, enough to hold 0..N.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/div_unit_div_step.sv
// Combinational N+1-bit trial subtractor: T = p_sh - {1'b0, b_mag}, built as a
// ripple of full_adder cells with inverted subtrahend and carry-in 1.
module div_step #(
  parameter int N = 32
) (
  input  logic [N:0]   p_sh,
  input  logic [N-1:0] b_mag,
  output logic [N-1:0] diff,
  output logic         restore
);

  logic [N:0] carry;
  logic       t_msb;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .x   (p_sh[i]),
      .y   (~b_mag[i]),
      .cin (carry[i]),
      .s   (diff[i]),
      .cout(carry[i+1])
    );
  end

  // Top bit of the subtrahend is 0, so its inverted input is a constant 1 and
  // no carry-out is needed: the MSB of T reduces to an XNOR.
  assign t_msb   = ~(p_sh[N] ^ carry[N]);
  assign restore = t_msb;

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the divider's trial subtractor.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: one quotient bit per clock,
// sign fix-up at the end, and a one-cycle divide-by-zero path.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  localparam int            KW     = cnt_width(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [KW-1:0] K_ONE  = KW'(1);

  state_e         state_q, state_d;
  logic [N-1:0]   p_q, p_d;
  logic [N-1:0]   d_q, d_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   r_q, r_d;
  logic [KW-1:0]  k_q, k_d;
  logic           sa_q, sa_d;
  logic           sb_q, sb_d;
  logic           done_q, done_d;
  logic           dz_q, dz_d;
  logic           busy_o;

  logic [N:0]     p_sh;
  logic [N-1:0]   diff;
  logic           restore;

  // P always ends an iteration below |b|, so it is kept N bits wide; the
  // shifted value feeding the subtractor carries the extra (N+1th) bit.
  assign p_sh = {p_q, d_q[N-1]};

  div_step #(.N(N)) u_step (
    .p_sh   (p_sh),
    .b_mag  (b_q),
    .diff   (diff),
    .restore(restore)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      d_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      d_q     <= d_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      k_q     <= k_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (b == '0) ? ST_ZERO : ST_RUN;
      end
      ST_RUN: begin
        if (k_q == K_LAST) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      ST_ZERO: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == ST_RUN);
  end

  // Datapath: D holds |a| on entry and shifts quotient bits in from the right.
  always_comb begin
    p_d    = p_q;
    d_d    = d_q;
    b_d    = b_q;
    q_d    = q_q;
    r_d    = r_q;
    k_d    = k_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    done_d = 1'b0;
    dz_d   = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sa_d = is_signed & a[N-1];
          sb_d = is_signed & b[N-1];
          d_d  = sa_d ? -a : a;
          b_d  = sb_d ? -b : b;
          p_d  = '0;
          k_d  = '0;
        end
      end
      ST_RUN: begin
        p_d = restore ? p_sh[N-1:0] : diff;
        d_d = {d_q[N-2:0], ~restore};
        k_d = k_q + K_ONE;
      end
      ST_FIX: begin
        q_d    = (sa_q ^ sb_q) ? -d_q : d_q;
        r_d    = sa_q ? -p_q : p_q;
        dz_d   = 1'b0;
        done_d = 1'b1;
      end
      ST_ZERO: begin
        // D still holds |a|; undo the magnitude step to return a unchanged.
        q_d    = '1;
        r_d    = sa_q ? -d_q : d_q;
        dz_d   = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign q        = q_q;
  assign r        = r_q;
  assign busy     = busy_o;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed MIPS cases, protocol corners and
// randomized operands against an arithmetic reference model.
module tb_div_unit;

  localparam int N = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         busy;
  logic         done;
  logic         div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .is_signed(is_signed),
    .a        (a),
    .b        (b),
    .q        (q),
    .r        (r),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic, 64-bit signed to sidestep the overflow case.
  task automatic model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic ms,
                       output logic [N-1:0] eq, output logic [N-1:0] er, output logic ez);
    longint sa, sb;
    if (mb == '0) begin
      eq = '1;
      er = ma;
      ez = 1'b1;
    end else if (ms) begin
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      eq = N'(sa / sb);
      er = N'(sa % sb);
      ez = 1'b0;
    end else begin
      eq = ma / mb;
      er = ma % mb;
      ez = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [N-1:0] la, input logic [N-1:0] lb, input logic ls);
    a         = la;
    b         = lb;
    is_signed = ls;
    start     = 1'b1;
  endtask

  // Waits through the accepting edge, measures latency/busy, checks results.
  // poke_at >= 0 pulses a rogue start with other operands that many cycles in.
  task automatic finish_op(input logic [N-1:0] fa, input logic [N-1:0] fb, input logic fs,
                           input int poke_at, input bit chk_pulse);
    logic [N-1:0] eq, er;
    logic         ez;
    int           lat;
    int           busy_cnt;
    model(fa, fb, fs, eq, er, ez);
    @(posedge clk); #1;
    start    = 1'b0;
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      if (lat == poke_at) begin
        a     = $urandom;
        b     = 32'd5;
        start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (busy) busy_cnt++;
    end
    if (!done) begin
      check("timeout", 32'(lat), 32'd0);
    end else begin
      check("q", q, eq);
      check("r", r, er);
      check("div_zero", {31'd0, div_zero}, {31'd0, ez});
      check("latency", 32'(lat), (fb == '0) ? 32'd1 : 32'(N + 1));
      check("busy_cycles", 32'(busy_cnt), (fb == '0) ? 32'd0 : 32'(N));
      if (chk_pulse) begin
        @(posedge clk); #1;
        check("done_pulse", {31'd0, done}, 32'd0);
        check("q_hold", q, eq);
      end
    end
  endtask

  task automatic run_op(input logic [N-1:0] ra, input logic [N-1:0] rb, input logic rs);
    @(negedge clk);
    launch(ra, rb, rs);
    finish_op(ra, rb, rs, -1, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] ra, rb;
    logic         rs;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_q", q, 32'd0);
    check("rst_r", r, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed cases
    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op(32'h0000_1234, 32'd0, 1'b0);
    run_op(32'd9, 32'd3, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(32'hFFFF_FFF0, 32'd0, 1'b1);
    run_op(32'd5, 32'd9, 1'b0);

    // Start during a busy divide is ignored
    @(negedge clk);
    launch(32'd1000, 32'd7, 1'b0);
    finish_op(32'd1000, 32'd7, 1'b0, 5, 1'b1);

    // Start in the done cycle is accepted back-to-back (including into ZERO)
    @(negedge clk);
    launch(32'd12345, 32'd10, 1'b0);
    finish_op(32'd12345, 32'd10, 1'b0, -1, 1'b0);
    launch(32'hFFFF_FF9C, 32'd9, 1'b1);
    finish_op(32'hFFFF_FF9C, 32'd9, 1'b1, -1, 1'b0);
    launch(32'd77, 32'd0, 1'b0);
    finish_op(32'd77, 32'd0, 1'b0, -1, 1'b1);

    // Reset in the middle of a divide
    @(negedge clk);
    launch(32'd4000, 32'd3, 1'b0);
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_q", q, 32'd0);
    check("midrst_r", r, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_dz", {31'd0, div_zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(32'd4000, 32'd3, 1'b0);

    // Randomized operands
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = -32'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
